arith_unit_divider: RTL
=======================

// Module: arith_unit_divider
// PURPOSE
//  Inverse of the (A+B)*(C-D) pipelined arithmetic unit: recovers S = Y / (C-D) and R = Y % (C-D).
//  Multi-cycle signed restoring divider with valid/ready handshakes on input and output.
//  Sits downstream of the multiply pipeline for self-check and inverse-path use.
//  One transaction in flight; in_ready is low while busy.
// PARAMETERS
//  YW   16  dividend / quotient width (signed)
//  OW    8  C, D operand width (signed); divisor width DW = OW+1
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      reset: asynchronous, active-high
//  in_valid   in   1      Y/C/D valid
//  in_ready   out  1      block can accept (high only in IDLE)
//  Y          in   YW     signed dividend
//  C          in   OW     signed operand
//  D          in   OW     signed operand; divisor = C - D, computed at DW bits
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  Q          out  YW     signed quotient, truncated toward zero
//  R          out  DW     signed remainder; sign follows Y; |R| < |C-D|
//  dbz        out  1      divide-by-zero flag, valid with out_valid
//  ovf        out  1      quotient-overflow flag, valid with out_valid
// BEHAVIOUR
//  - Reset: state IDLE; in_ready=1 after reset release; out_valid, Q, R, dbz, ovf = 0; internal regs 0.
//  - Accept on the edge where in_valid & in_ready. Y, C, D are captured; divisor = C - D at DW bits.
//    Inputs are ignored at all other times.
//  - FSM states: IDLE, PREP, CALC, SIGN, DONE.
//    IDLE -accept-> PREP.
//    PREP: record signs; take |Y| and |div|; counter = YW-1.
//      If div == 0: -> DONE with Q=0, R=0, dbz=1.
//      Else -> CALC.
//    CALC: one restoring step per clock, MSB first (shift in dividend bit, trial subtract, set q bit).
//      Count down; at count 0 -> SIGN.
//    SIGN: negate Q if sign(Y) != sign(div); negate R if Y < 0.
//      If the unsigned quotient is 2^(YW-1) and the result is positive (Y = -32768, div = -1):
//      Q = 2^(YW-1)-1 (saturate to 32767) and ovf=1. Then -> DONE.
//    DONE: out_valid=1. Q/R/dbz/ovf held stable until out_ready. On out_valid & out_ready -> IDLE.
//  - Latency: accept edge e0; out_valid rises after edge e0+18 (1 PREP + 16 CALC + 1 SIGN).
//    Divide-by-zero: out_valid rises after e0+1.
//  - Throughput: next accept is possible on the edge after the output handshake completes.
//    No overlap; in_ready=0 in PREP..DONE.
//  - Backpressure: out_ready low in DONE stalls indefinitely; outputs must not change while stalled.
//  - Flags dbz and ovf clear on the next accept.
//  - Reset mid-operation: the transaction is dropped; back to IDLE with reset values; no spurious out_valid.
//  - Widths: the remainder accumulator is DW+1 bits to hold the trial subtract.
//    |div| <= 256 needs DW bits unsigned; size the accumulator accordingly.
//  - Q, R, and flags are registered; no combinational path from inputs to outputs.
// STRUCTURE
//  - Shared package arith_pkg: YW/OW/DW constants; FSM state enum (IDLE, PREP, CALC, SIGN, DONE).
//    The multiply unit also uses these widths.
//  - Sub-module div_step: combinational single restoring iteration.
//    Inputs: {rem, next dividend bit}, |div|. Outputs: new rem, q bit.
//  - Top level holds the FSM, counter, sign logic, saturation, and handshake registers.
// TESTING
//  - Basic: Y=60, C=9, D=4 (div 5) -> Q=12, R=0, dbz=0, ovf=0.
//    out_valid exactly 18 cycles after the accept edge.
//  - Signs: Y=-7, div 2 -> Q=-3, R=-1. Y=7, div -2 -> Q=-3, R=1. Y=-7, div -2 -> Q=3, R=-1.
//  - Divide by zero: Y=100, C=D=33 -> dbz=1, Q=0, R=0; out_valid 1 cycle after accept.
//  - Overflow: Y=-32768, C=0, D=1 -> Q=32767, ovf=1.
//    Extreme divisor: Y=-32768, C=-128, D=127 (div -255) -> Q=128, R=-128.
//  - Backpressure: hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0.
//    Release -> IDLE, in_ready=1 next cycle.
//  - Reset mid-CALC: assert rst at cycle 8 -> all outputs 0 immediately.
//    After release, a new transaction (Y=60, div 5) completes correctly.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared widths, FSM state encoding and small helpers for the arithmetic unit
// and its inverse divider.
package arith_pkg;

  localparam int unsigned YW = 16;       // dividend / quotient width
  localparam int unsigned OW = 8;        // C, D operand width
  localparam int unsigned DW = OW + 1;   // divisor / remainder width
  localparam int unsigned CW = $clog2(YW);

  // Magnitude of the most negative quotient, and the positive saturation value.
  localparam logic [YW-1:0] QMagMin = {1'b1, {(YW-1){1'b0}}};
  localparam logic [YW-1:0] QSatPos = {1'b0, {(YW-1){1'b1}}};

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    CALC,
    SIGN,
    DONE
  } div_state_e;

  // Two's-complement magnitude; the most negative value maps to its unsigned magnitude.
  function automatic logic [YW-1:0] abs_y(input logic [YW-1:0] v);
    return v[YW-1] ? -v : v;
  endfunction

  function automatic logic [DW-1:0] abs_d(input logic [DW-1:0] v);
    return v[DW-1] ? -v : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: trial-subtract the divisor magnitude from the
// shifted partial remainder and keep the difference when it does not go negative.
module div_step
  import arith_pkg::*;
(
  input  logic [DW:0]   acc,      // {partial remainder, next dividend bit}
  input  logic [DW-1:0] divisor,  // |C - D|
  output logic [DW-1:0] rem,
  output logic          qbit
);

  logic [DW:0] trial;

  assign trial = acc - {1'b0, divisor};
  assign qbit  = (acc >= {1'b0, divisor});
  // Remainder stays below |divisor| <= 255, so DW bits always hold the result.
  assign rem   = qbit ? trial[DW-1:0] : acc[DW-1:0];

endmodule

// File: rtl/arith_unit_divider.sv
// Multi-cycle signed restoring divider: Q = Y / (C-D), R = Y % (C-D), with
// valid/ready handshakes, divide-by-zero and quotient-overflow flags.
module arith_unit_divider
  import arith_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [YW-1:0] Y,
  input  logic [OW-1:0] C,
  input  logic [OW-1:0] D,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [YW-1:0] Q,
  output logic [DW-1:0] R,
  output logic          dbz,
  output logic          ovf
);

  div_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [YW-1:0] y_q, y_d;
  logic [DW-1:0] div_q, div_d;
  logic          y_neg_q, y_neg_d;
  logic          d_neg_q, d_neg_d;
  logic [YW-1:0] dvd_q, dvd_d;       // dividend bits out at MSB, quotient bits in at LSB
  logic [DW-1:0] rem_q, rem_d;
  logic [DW-1:0] absdiv_q, absdiv_d;
  logic [YW-1:0] q_q, q_d;
  logic [DW-1:0] r_q, r_d;
  logic          dbz_q, dbz_d;
  logic          ovf_q, ovf_d;

  logic [DW-1:0] step_rem;
  logic          step_qbit;
  logic          q_neg;

  div_step u_div_step (
    .acc     ({rem_q, dvd_q[YW-1]}),
    .divisor (absdiv_q),
    .rem     (step_rem),
    .qbit    (step_qbit)
  );

  assign q_neg = y_neg_q ^ d_neg_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      y_q      <= '0;
      div_q    <= '0;
      y_neg_q  <= 1'b0;
      d_neg_q  <= 1'b0;
      dvd_q    <= '0;
      rem_q    <= '0;
      absdiv_q <= '0;
      q_q      <= '0;
      r_q      <= '0;
      dbz_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      y_q      <= y_d;
      div_q    <= div_d;
      y_neg_q  <= y_neg_d;
      d_neg_q  <= d_neg_d;
      dvd_q    <= dvd_d;
      rem_q    <= rem_d;
      absdiv_q <= absdiv_d;
      q_q      <= q_d;
      r_q      <= r_d;
      dbz_q    <= dbz_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    y_d      = y_q;
    div_d    = div_q;
    y_neg_d  = y_neg_q;
    d_neg_d  = d_neg_q;
    dvd_d    = dvd_q;
    rem_d    = rem_q;
    absdiv_d = absdiv_q;
    q_d      = q_q;
    r_d      = r_q;
    dbz_d    = dbz_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          y_d     = Y;
          div_d   = {C[OW-1], C} - {D[OW-1], D};
          dbz_d   = 1'b0;
          ovf_d   = 1'b0;
          state_d = PREP;
        end
      end
      PREP: begin
        y_neg_d  = y_q[YW-1];
        d_neg_d  = div_q[DW-1];
        dvd_d    = abs_y(y_q);
        absdiv_d = abs_d(div_q);
        rem_d    = '0;
        cnt_d    = CW'(YW - 1);
        if (div_q == '0) begin
          q_d     = '0;
          r_d     = '0;
          dbz_d   = 1'b1;
          state_d = DONE;
        end else begin
          state_d = CALC;
        end
      end
      CALC: begin
        dvd_d = {dvd_q[YW-2:0], step_qbit};
        rem_d = step_rem;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = SIGN;
        end
      end
      SIGN: begin
        // Only -2^(YW-1) / -1 yields a positive quotient that does not fit.
        if (!q_neg && (dvd_q == QMagMin)) begin
          q_d   = QSatPos;
          ovf_d = 1'b1;
        end else begin
          q_d = q_neg ? -dvd_q : dvd_q;
        end
        r_d     = y_neg_q ? -rem_q : rem_q;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign Q         = q_q;
  assign R         = r_q;
  assign dbz       = dbz_q;
  assign ovf       = ovf_q;

  stall_holds_result : assert property (
    @(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(Q) && $stable(R) &&
                                   $stable(dbz) && $stable(ovf))
  );

endmodule
